bp_fe_gshare_predictor: RTL and testbench

Parametrised gshare direction predictor for the FE pc_gen stage. It replaces the per-PC 2-bit BHT with a table of saturating counters, indexed by PC XOR global history, with counter width, table depth and history length all configurable. It keeps a speculative global history register (GHR) and restores it on a backend mispredict. The table is initialised by a hardware walk after reset. The {index, GHR snapshot} pair is exported so it can be forwarded in branch metadata and returned on update.

---
 rtl/bp_fe_gshare_predictor.sv | 161 ++++++++++++++++
 tb/tb_bp_fe_gshare_predictor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_gshare_predictor.sv
// Gshare direction predictor: PC^GHR indexed saturating counters, speculative GHR with restore,
// hardware init walk after reset. Optional macro BP_FE_GSHARE_BYPASS_EN forwards same-cycle updates.
module bp_fe_gshare_predictor #(
    parameter int eaddr_width_p    = 64,
    parameter int bht_indx_width_p = 9,
    parameter int ghist_width_p    = 8,
    parameter int ctr_width_p      = 2,
    parameter int pc_lsb_p         = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        r_v_i,
    input  logic [eaddr_width_p-1:0]    pc_r_i,
    input  logic                        spec_v_i,
    output logic                        pred_v_o,
    output logic                        predict_o,
    output logic [bht_indx_width_p-1:0] pred_idx_o,
    output logic [ghist_width_p-1:0]    pred_ghist_o,
    input  logic                        w_v_i,
    input  logic [bht_indx_width_p-1:0] w_idx_i,
    input  logic                        w_taken_i,
    input  logic                        w_mispredict_i,
    input  logic [ghist_width_p-1:0]    w_ghist_i,
    output logic                        busy_o
);

    localparam int lp_entries = 1 << bht_indx_width_p;

    typedef logic [ctr_width_p-1:0] ctr_t;
    typedef logic [bht_indx_width_p-1:0] idx_t;

    localparam ctr_t lp_ctr_init = ctr_t'((1 << (ctr_width_p - 1)) - 1);
    localparam ctr_t lp_ctr_max  = '1;

    typedef enum logic [1:0] {
        e_reset,
        e_init,
        e_ready
    } state_e;

    function automatic ctr_t sat_update(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == lp_ctr_max) ? c : c + ctr_t'(1);
        end
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

    state_e                   r_state;
    idx_t                     r_cnt;
    logic [ghist_width_p-1:0] r_ghr;
    ctr_t                     r_tbl [lp_entries];

    logic                     r_pred_v;
    logic                     r_predict;
    idx_t                     r_pred_idx;
    logic [ghist_width_p-1:0] r_pred_ghist;

    idx_t                     w_ghr_ext;
    idx_t                     w_idx;
    ctr_t                     w_rd_ctr;
    ctr_t                     w_upd_ctr;
    logic                     w_upd_en;
    logic                     w_lookup_en;
    logic                     w_lookup_bit;
    logic [ghist_width_p-1:0] w_ghr_restore;
    logic [ghist_width_p-1:0] w_ghr_spec;
    logic                     w_unused;

    // PC bits outside the index window and the oldest snapshot bit are intentionally dropped
    assign w_unused = ^{pc_r_i, w_ghist_i};

    always_comb begin
        w_ghr_ext = '0;
        w_ghr_ext[ghist_width_p-1:0] = r_ghr;
    end

    assign w_idx       = pc_r_i[pc_lsb_p +: bht_indx_width_p] ^ w_ghr_ext;
    assign w_rd_ctr    = r_tbl[w_idx];
    assign w_upd_ctr   = sat_update(r_tbl[w_idx_i], w_taken_i);
    assign w_upd_en    = reset_n_i && w_v_i && (r_state == e_ready);
    assign w_lookup_en = r_v_i && (r_state == e_ready);
    assign busy_o      = (r_state != e_ready);

`ifdef BP_FE_GSHARE_BYPASS_EN
    assign w_lookup_bit = (w_upd_en && (w_idx_i == w_idx)) ? w_upd_ctr[ctr_width_p-1]
                                                           : w_rd_ctr[ctr_width_p-1];
`else
    assign w_lookup_bit = w_rd_ctr[ctr_width_p-1];
`endif

    generate
        if (ghist_width_p == 1) begin : g_ghr_one
            assign w_ghr_restore = w_taken_i;
            assign w_ghr_spec    = r_predict;
        end else begin : g_ghr_multi
            assign w_ghr_restore = {w_ghist_i[ghist_width_p-2:0], w_taken_i};
            assign w_ghr_spec    = {r_ghr[ghist_width_p-2:0], r_predict};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= e_reset;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                e_reset: r_state <= e_init;
                e_init: begin
                    r_cnt <= r_cnt + idx_t'(1);
                    if (r_cnt == '1) begin
                        r_state <= e_ready;
                    end
                end
                e_ready: r_state <= e_ready;
                default: r_state <= e_reset;
            endcase
        end
    end

    // Counter storage is left unreset; the init walk establishes its contents
    always_ff @(posedge clk_i) begin
        if (reset_n_i && (r_state == e_init)) begin
            r_tbl[r_cnt] <= lp_ctr_init;
        end else if (w_upd_en) begin
            r_tbl[w_idx_i] <= w_upd_ctr;
        end
    end

    // Restore beats speculation and keeps working during the init walk
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ghr <= '0;
        end else if (w_v_i && w_mispredict_i) begin
            r_ghr <= w_ghr_restore;
        end else if (spec_v_i) begin
            r_ghr <= w_ghr_spec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_pred_v     <= 1'b0;
            r_predict    <= 1'b0;
            r_pred_idx   <= '0;
            r_pred_ghist <= '0;
        end else begin
            r_pred_v <= w_lookup_en;
            if (w_lookup_en) begin
                r_predict    <= w_lookup_bit;
                r_pred_idx   <= w_idx;
                r_pred_ghist <= r_ghr;
            end
        end
    end

    assign pred_v_o     = r_pred_v;
    assign predict_o    = r_predict;
    assign pred_idx_o   = r_pred_idx;
    assign pred_ghist_o = r_pred_ghist;

endmodule

// File: tb/tb_bp_fe_gshare_predictor.sv
// Directed bench for bp_fe_gshare_predictor: vector table for steady-state behaviour,
// hand sequences for init walk length, in-flight reset and mid-walk reset.
module tb_bp_fe_gshare_predictor;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        r_v_i;
    logic [63:0] pc_r_i;
    logic        spec_v_i;
    logic        pred_v_o;
    logic        predict_o;
    logic [8:0]  pred_idx_o;
    logic [7:0]  pred_ghist_o;
    logic        w_v_i;
    logic [8:0]  w_idx_i;
    logic        w_taken_i;
    logic        w_mispredict_i;
    logic [7:0]  w_ghist_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

`ifdef BP_FE_GSHARE_BYPASS_EN
    localparam logic expBypass = 1'b1;
`else
    localparam logic expBypass = 1'b0;
`endif

    bp_fe_gshare_predictor dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .r_v_i          (r_v_i),
        .pc_r_i         (pc_r_i),
        .spec_v_i       (spec_v_i),
        .pred_v_o       (pred_v_o),
        .predict_o      (predict_o),
        .pred_idx_o     (pred_idx_o),
        .pred_ghist_o   (pred_ghist_o),
        .w_v_i          (w_v_i),
        .w_idx_i        (w_idx_i),
        .w_taken_i      (w_taken_i),
        .w_mispredict_i (w_mispredict_i),
        .w_ghist_i      (w_ghist_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rv;
        logic [63:0] pc;
        logic        spec;
        logic        wv;
        logic [8:0]  widx;
        logic        wt;
        logic        wm;
        logic [7:0]  wg;
        logic        expPv;
        logic        expPred;
        logic [8:0]  expIdx;
        logic [7:0]  expGhist;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic rv, input logic [63:0] pc, input logic spec,
                                input logic wv, input logic [8:0] widx, input logic wt,
                                input logic wm, input logic [7:0] wg,
                                input logic ePv, input logic ePred,
                                input logic [8:0] eIdx, input logic [7:0] eGh);
        vec_t v;
        v.rv = rv; v.pc = pc; v.spec = spec; v.wv = wv; v.widx = widx; v.wt = wt;
        v.wm = wm; v.wg = wg; v.expPv = ePv; v.expPred = ePred; v.expIdx = eIdx;
        v.expGhist = eGh;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        r_v_i = 1'b0; pc_r_i = '0; spec_v_i = 1'b0; w_v_i = 1'b0; w_idx_i = '0;
        w_taken_i = 1'b0; w_mispredict_i = 1'b0; w_ghist_i = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        r_v_i = v.rv; pc_r_i = v.pc; spec_v_i = v.spec; w_v_i = v.wv; w_idx_i = v.widx;
        w_taken_i = v.wt; w_mispredict_i = v.wm; w_ghist_i = v.wg;
        tick();
        idleInputs();
    endtask

    task automatic countBusy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (busy_o) n++;
            else break;
        end
    endtask

    task automatic lookup(input string name, input logic [63:0] pc, input logic ePred,
                          input logic [8:0] eIdx, input logic [7:0] eGh);
        r_v_i = 1'b1; pc_r_i = pc;
        tick();
        idleInputs();
        checkOutput({name, "_pv"}, 64'(pred_v_o), 64'd1);
        checkOutput({name, "_pred"}, 64'(predict_o), 64'(ePred));
        checkOutput({name, "_idx"}, 64'(pred_idx_o), 64'(eIdx));
        checkOutput({name, "_ghist"}, 64'(pred_ghist_o), 64'(eGh));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic sawPv;
        logic done;

        //               rv pc        sp wv idx    wt wm wg     pv pr idx    gh
        vecs[0]  = mk(1, 64'h0,   0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h000, 8'h00);
        vecs[1]  = mk(1, 64'h7FC, 0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h1FF, 8'h00);
        vecs[2]  = mk(1, 64'h400, 0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h100, 8'h00);
        vecs[3]  = mk(0, 64'h0,   0, 0, 9'h0,  0, 0, 8'h0, 0, 0, 9'h100, 8'h00);
        vecs[4]  = mk(0, 64'h0,   0, 1, 9'h5,  1, 0, 8'h0, 0, 0, 9'h100, 8'h00);
        vecs[5]  = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 1, 9'h005, 8'h00);
        vecs[6]  = mk(0, 64'h0,   0, 1, 9'h5,  1, 0, 8'h0, 0, 1, 9'h005, 8'h00);
        vecs[7]  = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 1, 9'h005, 8'h00);
        vecs[8]  = mk(0, 64'h0,   0, 1, 9'h5,  1, 0, 8'h0, 0, 1, 9'h005, 8'h00);
        vecs[9]  = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 1, 9'h005, 8'h00);
        vecs[10] = mk(0, 64'h0,   0, 1, 9'h5,  0, 0, 8'h0, 0, 1, 9'h005, 8'h00);
        vecs[11] = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 1, 9'h005, 8'h00);
        vecs[12] = mk(0, 64'h0,   0, 1, 9'h5,  0, 0, 8'h0, 0, 1, 9'h005, 8'h00);
        vecs[13] = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h005, 8'h00);
        vecs[14] = mk(0, 64'h0,   0, 1, 9'h5,  0, 0, 8'h0, 0, 0, 9'h005, 8'h00);
        vecs[15] = mk(0, 64'h0,   0, 1, 9'h5,  0, 0, 8'h0, 0, 0, 9'h005, 8'h00);
        vecs[16] = mk(0, 64'h0,   0, 1, 9'h5,  1, 0, 8'h0, 0, 0, 9'h005, 8'h00);
        vecs[17] = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h005, 8'h00);
        vecs[18] = mk(0, 64'h0,   0, 1, 9'h10, 1, 1, 8'h01, 0, 0, 9'h005, 8'h00);
        vecs[19] = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h006, 8'h03);
        vecs[20] = mk(1, 64'h4C,  0, 0, 9'h0,  0, 0, 8'h0, 1, 1, 9'h010, 8'h03);
        vecs[21] = mk(0, 64'h0,   1, 0, 9'h0,  0, 0, 8'h0, 0, 1, 9'h010, 8'h03);
        vecs[22] = mk(0, 64'h0,   1, 1, 9'h20, 0, 1, 8'hAA, 0, 1, 9'h010, 8'h03);
        vecs[23] = mk(1, 64'h0,   0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h054, 8'h54);
        vecs[24] = mk(0, 64'h0,   1, 0, 9'h0,  0, 0, 8'h0, 0, 0, 9'h054, 8'h54);
        vecs[25] = mk(1, 64'h0,   0, 0, 9'h0,  0, 0, 8'h0, 1, 0, 9'h0A8, 8'hA8);
        vecs[26] = mk(0, 64'h0,   0, 1, 9'h21, 0, 1, 8'h00, 0, 0, 9'h0A8, 8'hA8);
        vecs[27] = mk(1, 64'h14,  0, 1, 9'h5,  1, 0, 8'h0, 1, expBypass, 9'h005, 8'h00);
        vecs[28] = mk(1, 64'h14,  0, 0, 9'h0,  0, 0, 8'h0, 1, 1, 9'h005, 8'h00);

        idleInputs();
        reset_n_i = 1'b0;
        repeat (3) tick();
        checkOutput("rst_pv", 64'(pred_v_o), 64'd0);
        checkOutput("rst_pred", 64'(predict_o), 64'd0);
        checkOutput("rst_idx", 64'(pred_idx_o), 64'd0);
        checkOutput("rst_ghist", 64'(pred_ghist_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd1);

        reset_n_i = 1'b1;
        countBusy(n);
        checkOutput("init_busy_cycles", 64'(n), 64'd512);

        for (int i = 0; i < 29; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_pv", i), 64'(pred_v_o), 64'(vecs[i].expPv));
            checkOutput($sformatf("vec%0d_pred", i), 64'(predict_o), 64'(vecs[i].expPred));
            checkOutput($sformatf("vec%0d_idx", i), 64'(pred_idx_o), 64'(vecs[i].expIdx));
            checkOutput($sformatf("vec%0d_ghist", i), 64'(pred_ghist_o), 64'(vecs[i].expGhist));
        end

        // Reset arriving with a lookup request must squash the result
        r_v_i = 1'b1; pc_r_i = 64'h14; reset_n_i = 1'b0;
        tick();
        idleInputs();
        checkOutput("inflight_pv", 64'(pred_v_o), 64'd0);
        checkOutput("inflight_pred", 64'(predict_o), 64'd0);
        checkOutput("inflight_busy", 64'(busy_o), 64'd1);
        tick();

        reset_n_i = 1'b1;
        repeat (200) tick();
        checkOutput("midwalk_busy", 64'(busy_o), 64'd1);
        reset_n_i = 1'b0;
        tick();
        checkOutput("midwalk_rst_busy", 64'(busy_o), 64'd1);
        reset_n_i = 1'b1;

        n = 0; sawPv = 1'b0; done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            idleInputs();
            if (i == 100) begin
                r_v_i = 1'b1; pc_r_i = 64'h14;
            end
            if (i == 300) begin
                w_v_i = 1'b1; w_mispredict_i = 1'b1; w_idx_i = 9'h5; w_taken_i = 1'b1;
                w_ghist_i = 8'h01;
            end
            if (i == 301) begin
                w_v_i = 1'b1; w_idx_i = 9'h5; w_taken_i = 1'b1;
            end
            tick();
            if (pred_v_o) sawPv = 1'b1;
            if (busy_o) n++;
            else done = 1'b1;
        end
        idleInputs();
        checkOutput("restart_busy_cycles", 64'(n), 64'd512);
        checkOutput("walk_no_pred_v", 64'(sawPv), 64'd0);

        lookup("post_walk_idx5", 64'h18, 1'b0, 9'h005, 8'h03);
        lookup("post_walk_idx6", 64'h14, 1'b0, 9'h006, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
